// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state encoding and constants for the APB arbiter
package apb_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] PSEL_NONE = 2'b00;
    localparam logic [1:0] PSEL_RM   = 2'b01;
    localparam logic [1:0] PSEL_ICN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant memory
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req_i[1:0]  - request from requester 0 / 1
//   update_i    - grant is being taken this cycle; remember the winner
//   gnt_o[1:0]  - one-hot combinational grant (0 when no request)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // last_q = index of the most recent winner; starts at 1 so m0 wins the first tie.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (update_i && (|req_i)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - shares one APB target bus (rm / icn) between two requesters
//
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   m0_* / m1_*                      - requester side: psel/pwrite/pstrb/paddr/pwdata in,
//                                      prdata/pready/pslverr out (pready is a one-cycle pulse)
//   psel[1:0], penable, pwrite,
//   pstrb, paddr, pwdata             - downstream APB master outputs, psel = {icn, rm}
//   prdata_rm/pready_rm/pslverr_rm   - rm target response
//   prdata_icn/pready_icn/pslverr_icn- icn target response
//   timeout_err                      - one-cycle pulse when an ACCESS phase is aborted
//   busy                             - transfer in progress (FSM not IDLE)
module apb_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SEL_BIT = 19,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_psel,
    input  logic              m0_pwrite,
    input  logic              m0_pstrb,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic              m1_psel,
    input  logic              m1_pwrite,
    input  logic              m1_pstrb,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic [1:0]        psel,
    output logic              penable,
    output logic              pwrite,
    output logic              pstrb,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata_rm,
    input  logic              pready_rm,
    input  logic              pslverr_rm,
    input  logic [DATA_W-1:0] prdata_icn,
    input  logic              pready_icn,
    input  logic              pslverr_icn,
    output logic              timeout_err,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the ACCESS cycle whose count reaches TIMEOUT.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e        state_q, state_d;
    logic              win_q, win_d;
    logic              pwrite_q, pwrite_d, pstrb_q, pstrb_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [1:0]        psel_q, psel_d;
    logic              penable_q, penable_d, busy_q, busy_d, to_q, to_d;
    logic              m0_pready_q, m0_pready_d, m0_pslverr_q, m0_pslverr_d;
    logic              m1_pready_q, m1_pready_d, m1_pslverr_q, m1_pslverr_d;
    logic [DATA_W-1:0] m0_prdata_q, m0_prdata_d, m1_prdata_q, m1_prdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        req, gnt;
    logic              arb_upd;
    logic              sel_icn, sel_ready, sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              done;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] win_addr;

    assign req = {m1_psel, m0_psel};

    rr_arb2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .update_i (arb_upd),
        .gnt_o    (gnt)
    );

    // Only the addressed target's response is looked at.
    assign sel_icn   = paddr_q[SEL_BIT];
    assign sel_ready = sel_icn ? pready_icn  : pready_rm;
    assign sel_err   = sel_icn ? pslverr_icn : pslverr_rm;
    assign sel_rdata = sel_icn ? prdata_icn  : prdata_rm;
    assign win_addr  = gnt[1] ? m1_paddr : m0_paddr;

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        pwrite_d     = pwrite_q;
        pstrb_d      = pstrb_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        cnt_d        = '0;
        to_d         = 1'b0;
        arb_upd      = 1'b0;
        done         = 1'b0;
        rsp_data     = '0;
        rsp_err      = 1'b0;
        m0_pready_d  = 1'b0;
        m0_pslverr_d = 1'b0;
        m0_prdata_d  = '0;
        m1_pready_d  = 1'b0;
        m1_pslverr_d = 1'b0;
        m1_prdata_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    arb_upd  = 1'b1;
                    win_d    = gnt[1];
                    pwrite_d = gnt[1] ? m1_pwrite : m0_pwrite;
                    pstrb_d  = gnt[1] ? m1_pstrb  : m0_pstrb;
                    pwdata_d = gnt[1] ? m1_pwdata : m0_pwdata;
                    paddr_d  = win_addr;
                    // psel is registered, so decode the winner's address now to show it in SETUP.
                    psel_d   = win_addr[SEL_BIT] ? PSEL_ICN : PSEL_RM;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    done     = 1'b1;
                    rsp_data = pwrite_q ? '0 : sel_rdata;
                    rsp_err  = sel_err;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    done     = 1'b1;
                    rsp_err  = 1'b1;
                    to_d     = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                end
                if (done) begin
                    psel_d    = PSEL_NONE;
                    penable_d = 1'b0;
                    state_d   = ST_RESP;
                    if (win_q) begin
                        m1_pready_d  = 1'b1;
                        m1_prdata_d  = rsp_data;
                        m1_pslverr_d = rsp_err;
                    end else begin
                        m0_pready_d  = 1'b1;
                        m0_prdata_d  = rsp_data;
                        m0_pslverr_d = rsp_err;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            win_q        <= 1'b0;
            pwrite_q     <= 1'b0;
            pstrb_q      <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            psel_q       <= PSEL_NONE;
            penable_q    <= 1'b0;
            busy_q       <= 1'b0;
            to_q         <= 1'b0;
            cnt_q        <= '0;
            m0_pready_q  <= 1'b0;
            m0_pslverr_q <= 1'b0;
            m0_prdata_q  <= '0;
            m1_pready_q  <= 1'b0;
            m1_pslverr_q <= 1'b0;
            m1_prdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            pwrite_q     <= pwrite_d;
            pstrb_q      <= pstrb_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            busy_q       <= busy_d;
            to_q         <= to_d;
            cnt_q        <= cnt_d;
            m0_pready_q  <= m0_pready_d;
            m0_pslverr_q <= m0_pslverr_d;
            m0_prdata_q  <= m0_prdata_d;
            m1_pready_q  <= m1_pready_d;
            m1_pslverr_q <= m1_pslverr_d;
            m1_prdata_q  <= m1_prdata_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign pstrb       = pstrb_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign busy        = busy_q;
    assign timeout_err = to_q;
    assign m0_pready   = m0_pready_q;
    assign m0_pslverr  = m0_pslverr_q;
    assign m0_prdata   = m0_prdata_q;
    assign m1_pready   = m1_pready_q;
    assign m1_pslverr  = m1_pslverr_q;
    assign m1_prdata   = m1_prdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - directed self-checking bench for apb_arbiter
module tb_apb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_psel = 0, m0_pwrite = 0, m0_pstrb = 0;
    logic [19:0] m0_paddr = '0;
    logic [15:0] m0_pwdata = '0;
    logic [15:0] m0_prdata;
    logic        m0_pready, m0_pslverr;
    logic        m1_psel = 0, m1_pwrite = 0, m1_pstrb = 0;
    logic [19:0] m1_paddr = '0;
    logic [15:0] m1_pwdata = '0;
    logic [15:0] m1_prdata;
    logic        m1_pready, m1_pslverr;
    logic [1:0]  psel;
    logic        penable, pwrite, pstrb;
    logic [19:0] paddr;
    logic [15:0] pwdata;
    logic [15:0] prdata_rm, prdata_icn;
    logic        pready_rm, pready_icn, pslverr_rm, pslverr_icn;
    logic        timeout_err, busy;

    // target model controls
    logic [7:0]  rm_wait = 0, icn_wait = 0;
    logic        rm_never = 0, rm_err = 0, icn_err = 0, icn_stray = 0;
    logic [15:0] rm_rdata = '0, icn_rdata = '0;
    logic [7:0]  acc_cnt;

    int n_checks = 0;
    int n_errors = 0;

    apb_arbiter #(.ADDR_W(20), .DATA_W(16), .SEL_BIT(19), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m0_psel(m0_psel), .m0_pwrite(m0_pwrite), .m0_pstrb(m0_pstrb), .m0_paddr(m0_paddr),
        .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_pwrite(m1_pwrite), .m1_pstrb(m1_pstrb), .m1_paddr(m1_paddr),
        .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata),
        .prdata_rm(prdata_rm), .pready_rm(pready_rm), .pslverr_rm(pslverr_rm),
        .prdata_icn(prdata_icn), .pready_icn(pready_icn), .pslverr_icn(pslverr_icn),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Targets: ready after <wait> extra ACCESS cycles; icn_stray forces an unselected pready.
    always @(posedge clk) begin
        if (reset) acc_cnt <= '0;
        else if (penable && !(psel[0] && pready_rm) && !(psel[1] && pready_icn)) acc_cnt <= acc_cnt + 8'd1;
        else acc_cnt <= '0;
    end
    assign pready_rm   = psel[0] & penable & ~rm_never & (acc_cnt >= rm_wait);
    assign pready_icn  = (psel[1] & penable & (acc_cnt >= icn_wait)) | icn_stray;
    assign prdata_rm   = rm_rdata;
    assign prdata_icn  = icn_rdata;
    assign pslverr_rm  = rm_err;
    assign pslverr_icn = icn_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [1:0]  tr_psel [0:63];
    logic        tr_pen  [0:63];
    int          r_lat;
    logic [15:0] r_rd;
    logic        r_err, r_to, r_to_after, r_pr_after, r_other;

    // Issue one transfer from requester m; trace index 0 is the request cycle T.
    task automatic xfer(input int m, input logic wr, input logic [19:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        if (m == 0) begin
            m0_pwrite = wr; m0_pstrb = wr; m0_paddr = a; m0_pwdata = d; m0_psel = 1'b1;
        end else begin
            m1_pwrite = wr; m1_pstrb = wr; m1_paddr = a; m1_pwdata = d; m1_psel = 1'b1;
        end
        r_lat = -1; r_rd = 'x; r_err = 1'bx; r_to = 1'bx; r_other = 1'bx;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            tr_psel[k] = psel;
            tr_pen[k]  = penable;
            if ((m == 0) ? m0_pready : m1_pready) begin
                r_lat   = k;
                r_rd    = (m == 0) ? m0_prdata : m1_prdata;
                r_err   = (m == 0) ? m0_pslverr : m1_pslverr;
                r_other = (m == 0) ? m1_pready : m0_pready;
                r_to    = timeout_err;
                break;
            end
        end
        if (r_lat < 0) $display("FAIL xfer_bound: got=no pready expected=pready within 40 cycles");
        m0_psel = 1'b0;
        m1_psel = 1'b0;
        @(negedge clk);
        r_pr_after = (m == 0) ? m0_pready : m1_pready;
        r_to_after = timeout_err;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int          n_done;
    int          who  [0:3];
    logic [1:0]  ps   [0:3];
    logic [15:0] rdv  [0:3];
    logic [1:0]  cur_psel;
    int          exp_who [0:3] = '{0, 1, 0, 1};
    logic [1:0]  exp_ps  [0:3] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        do_reset();
        @(negedge clk);
        chk("reset_outputs", 32'({psel, penable, busy, m0_pready, m1_pready, timeout_err, m0_pslverr}), 32'h0);
        chk("reset_paddr", 32'(paddr), 32'h0);

        // 1: m0 write, zero wait
        xfer(0, 1'b1, 20'h00010, 16'hA5A5);
        chk("t1_lat", 32'(r_lat), 32'd3);
        chk("t1_idle_psel", 32'(tr_psel[0]), 32'h0);
        chk("t1_setup_psel", 32'(tr_psel[1]), 32'h1);
        chk("t1_setup_pen", 32'(tr_pen[1]), 32'h0);
        chk("t1_access_pen", 32'(tr_pen[2]), 32'h1);
        chk("t1_access_psel", 32'(tr_psel[2]), 32'h1);
        chk("t1_done_psel", 32'(tr_psel[3]), 32'h0);
        chk("t1_pwdata", 32'(pwdata), 32'hA5A5);
        chk("t1_paddr", 32'(paddr), 32'h00010);
        chk("t1_pwrite", 32'(pwrite), 32'h1);
        chk("t1_pready_pulse", 32'(r_pr_after), 32'h0);

        // 2: both requesting after reset
        do_reset();
        rm_rdata = 16'h1111; icn_rdata = 16'h2222;
        @(posedge clk); #1;
        m0_pwrite = 0; m0_paddr = 20'h00020; m0_psel = 1;
        m1_pwrite = 0; m1_paddr = 20'h80004; m1_psel = 1;
        n_done = 0; cur_psel = 0;
        for (int i = 0; i < 4; i++) begin who[i] = 9; ps[i] = 2'b11; rdv[i] = 'x; end
        for (int k = 0; k < 60 && n_done < 4; k++) begin
            @(negedge clk);
            if (penable) cur_psel = psel;
            if (m0_pready || m1_pready) begin
                who[n_done] = m1_pready ? 1 : 0;
                ps[n_done]  = cur_psel;
                rdv[n_done] = m1_pready ? m1_prdata : m0_prdata;
                n_done++;
            end
        end
        m0_psel = 0; m1_psel = 0;
        chk("t2_count", 32'(n_done), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_grant%0d", i), 32'(who[i]), 32'(exp_who[i]));
            chk($sformatf("t2_psel%0d", i), 32'(ps[i]), 32'(exp_ps[i]));
        end
        chk("t2_m1_rdata", 32'(rdv[1]), 32'h2222);
        chk("t2_m0_rdata", 32'(rdv[2]), 32'h1111);

        // 3: m1 read at icn, 3 wait states
        icn_wait = 3; icn_rdata = 16'h1234; icn_err = 0;
        xfer(1, 1'b0, 20'h80010, 16'h0);
        chk("t3_lat", 32'(r_lat), 32'd6);
        chk("t3_rdata", 32'(r_rd), 32'h1234);
        chk("t3_err", 32'(r_err), 32'h0);
        chk("t3_m0_quiet", 32'(r_other), 32'h0);
        chk("t3_pready_pulse", 32'(r_pr_after), 32'h0);
        icn_wait = 0;

        // 4: write with slave error, then a normal read
        rm_err = 1; rm_rdata = 16'h7777;
        xfer(0, 1'b1, 20'h00040, 16'h0F0F);
        chk("t4_err", 32'(r_err), 32'h1);
        chk("t4_wr_rdata", 32'(r_rd), 32'h0);
        chk("t4_lat", 32'(r_lat), 32'd3);
        rm_err = 0; rm_wait = 1; rm_rdata = 16'hBEEF;
        xfer(0, 1'b0, 20'h00044, 16'h0);
        chk("t4b_err", 32'(r_err), 32'h0);
        chk("t4b_rdata", 32'(r_rd), 32'hBEEF);
        chk("t4b_lat", 32'(r_lat), 32'd4);
        rm_wait = 0;

        // 5: timeout; a stray icn pready must not complete an rm access
        rm_never = 1; icn_stray = 1; rm_rdata = 16'hFFFF;
        xfer(0, 1'b0, 20'h00050, 16'h0);
        chk("t5_lat", 32'(r_lat), 32'd10);
        chk("t5_err", 32'(r_err), 32'h1);
        chk("t5_rdata", 32'(r_rd), 32'h0);
        chk("t5_to_pulse", 32'(r_to), 32'h1);
        chk("t5_to_after", 32'(r_to_after), 32'h0);
        chk("t5_psel", 32'(tr_psel[r_lat < 0 ? 0 : r_lat]), 32'h0);
        chk("t5_pen_last_access", 32'(tr_pen[9]), 32'h1);
        icn_stray = 0;

        // 6: reset during ACCESS
        @(posedge clk); #1;
        m0_pwrite = 0; m0_paddr = 20'h00058; m0_psel = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_access", 32'(penable), 32'h1);
        reset = 1;
        @(negedge clk);
        chk("t6_reset_outputs", 32'({psel, penable, busy, m0_pready, m1_pready, timeout_err}), 32'h0);
        reset = 0; m0_psel = 0; rm_never = 0;
        xfer(1, 1'b1, 20'h00060, 16'h5A5A);
        chk("t6_m1_lat", 32'(r_lat), 32'd3);
        chk("t6_m0_abandoned", 32'(r_other), 32'h0);
        chk("t6_busy_idle", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
